// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared data-memory definitions (widths, funct3 codes, faults, LSU states)
// Shared by load_store_unit, lsu_load_extend and the memory block.
package riscv_mem_pkg;
    localparam int          XLEN       = 32;
    localparam logic [31:0] DATA_START = 32'hC000_0000;
    localparam logic [31:0] CODE_START = 32'h0000_0000;

    typedef enum logic [3:0] {
        BYTE     = 4'd0,
        HALFWORD = 4'd1,
        WORD     = 4'd2
    } Width;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        FAULT_NONE       = 2'd0,
        FAULT_MISALIGNED = 2'd1,
        FAULT_TIMEOUT    = 2'd2,
        FAULT_ILLEGAL    = 2'd3
    } fault_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GUARD,
        S_WAIT,
        S_RESP
    } lsu_state_e;

    // Decode-time fault for a request; illegal funct3 takes precedence over alignment.
    function automatic fault_e access_fault(input logic store, input logic [2:0] f3,
                                            input logic [1:0] addr_lo);
        if (store ? (f3 > F3_W) : (f3 == 3'd3 || f3 > F3_HU))
            return FAULT_ILLEGAL;
        if ((f3[1:0] == 2'd1 && addr_lo[0]) || (f3[1:0] == 2'd2 && addr_lo != 2'd0))
            return FAULT_MISALIGNED;
        return FAULT_NONE;
    endfunction
endpackage

// File: rtl/lsu_load_extend.sv
// lsu_load_extend: sign/zero extension of raw load data selected by RV32 funct3
// Ports: i_funct3 (load funct3), i_data (raw memory word), o_data (extended result).
module lsu_load_extend #(
    parameter int XLEN = riscv_mem_pkg::XLEN
) (
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_data,
    output logic [XLEN-1:0] o_data
);
    import riscv_mem_pkg::*;

    assign o_data = (i_funct3 == F3_B)  ? {{(XLEN-8){i_data[7]}}, i_data[7:0]}    :
                    (i_funct3 == F3_BU) ? {{(XLEN-8){1'b0}}, i_data[7:0]}         :
                    (i_funct3 == F3_H)  ? {{(XLEN-16){i_data[15]}}, i_data[15:0]} :
                    (i_funct3 == F3_HU) ? {{(XLEN-16){1'b0}}, i_data[15:0]}       :
                    i_data;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator on the data-memory main port
// Ports: clk/rst_n; req_* (pipeline request, req_ready high only in IDLE);
//        resp_* (one-cycle response with extended data or fault code);
//        address_main/width/read_request_main/write_request_main/write_data_main (memory drive);
//        data_main/busy_main (memory return).
module load_store_unit #(
    parameter int XLEN    = riscv_mem_pkg::XLEN,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic [1:0]      resp_fault,
    output logic [XLEN-1:0] address_main,
    output logic [3:0]      width,
    output logic            read_request_main,
    output logic            write_request_main,
    output logic [XLEN-1:0] write_data_main,
    input  logic [XLEN-1:0] data_main,
    input  logic            busy_main
);
    import riscv_mem_pkg::*;

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    lsu_state_e      r_state, w_next;
    logic            r_store;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_addr, r_wdata, r_rdata;
    fault_e          r_fault;
    logic [7:0]      r_cnt;
    fault_e          w_chk;
    logic [XLEN-1:0] w_ext;
    logic            w_active;
    Width            w_width;

    assign w_chk    = access_fault(req_store, req_funct3, req_addr[1:0]);
    assign w_width  = Width'({2'b00, r_funct3[1:0]});
    assign w_active = (r_state == S_ISSUE) || (r_state == S_GUARD) || (r_state == S_WAIT);

    lsu_load_extend #(.XLEN(XLEN)) u_ext (
        .i_funct3(r_funct3),
        .i_data  (data_main),
        .o_data  (w_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Completion is tested before the timeout so a busy drop on the limit cycle still succeeds.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = (w_chk == FAULT_NONE) ? S_ISSUE : S_RESP;
            S_ISSUE: w_next = S_GUARD;
            S_GUARD: w_next = S_WAIT;
            S_WAIT:  if (!busy_main || r_cnt == TO_LIMIT) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_store  <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_fault  <= FAULT_NONE;
            r_cnt    <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_store  <= req_store;
                    r_funct3 <= req_funct3;
                    r_addr   <= req_addr;
                    r_wdata  <= req_wdata;
                    r_rdata  <= '0;
                    r_fault  <= w_chk;
                end
                S_GUARD: r_cnt <= 8'd0;
                S_WAIT: begin
                    if (!busy_main) begin
                        r_rdata <= r_store ? '0 : w_ext;
                        r_fault <= FAULT_NONE;
                    end else if (r_cnt == TO_LIMIT)
                        r_fault <= FAULT_TIMEOUT;
                    else
                        r_cnt <= r_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // rst_n gates req_ready so it is low throughout reset even though the state reads IDLE.
    assign req_ready          = rst_n && (r_state == S_IDLE);
    assign resp_valid         = (r_state == S_RESP);
    assign resp_rdata         = (r_state == S_RESP) ? r_rdata : '0;
    assign resp_fault         = (r_state == S_RESP) ? r_fault : FAULT_NONE;
    assign address_main       = w_active ? r_addr : '0;
    assign width              = w_active ? w_width : BYTE;
    assign write_data_main    = w_active ? r_wdata : '0;
    assign read_request_main  = (r_state == S_ISSUE) && !r_store;
    assign write_request_main = (r_state == S_ISSUE) && r_store;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checks of load_store_unit against a behavioural model
module tb_load_store_unit;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_fault;
    logic [31:0] address_main, write_data_main, data_main;
    logic [3:0]  width;
    logic        read_request_main, write_request_main, busy_main;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .address_main(address_main), .width(width),
        .read_request_main(read_request_main), .write_request_main(write_request_main),
        .write_data_main(write_data_main), .data_main(data_main), .busy_main(busy_main)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Memory behaviour for the transaction about to be presented.
    int          t_nb;
    logic [31:0] t_md;

    // Model of the transaction in flight: k counts cycles since the accept edge.
    bit          act = 1'b0;
    int          k, fin;
    logic        m_st;
    logic [2:0]  m_f3;
    logic [31:0] m_ad, m_wd, m_rd;
    logic [1:0]  m_fault;
    bit          m_legal, m_mis;
    int          m_sz;

    // Observations used by directed literal checks.
    int          obs_rr, obs_wr, last_lat;
    logic [31:0] last_rd, last_wd;
    logic [1:0]  last_f;
    logic [3:0]  last_w0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: dut=%h expected=%h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ext(input logic [31:0] d, input logic [2:0] f);
        int bits;
        logic [63:0] v;
        bits = (f[1:0] == 2'd0) ? 8 : (f[1:0] == 2'd1) ? 16 : 32;
        v = {32'd0, d} & ((64'd1 << bits) - 64'd1);
        if (!f[2] && bits < 32 && v >= (64'd1 << (bits - 1)))
            v = v - (64'd1 << bits);
        return v[31:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            act = 1'b0;
        else if (act) begin
            k++;
            if (k > fin) act = 1'b0;
        end else if (req_valid && req_ready) begin
            act  = 1'b1;
            k    = 0;
            m_st = req_store;
            m_f3 = req_funct3;
            m_ad = req_addr;
            m_wd = req_wdata;
            m_legal = req_store ? (req_funct3 <= 3'd2) : (req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            m_sz    = 1 << req_funct3[1:0];
            m_mis   = (req_addr % m_sz) != 0;
            m_fault = !m_legal ? 2'd3 : m_mis ? 2'd1 : (t_nb > TMO) ? 2'd2 : 2'd0;
            fin     = (!m_legal || m_mis) ? 0 : 3 + ((t_nb < TMO) ? t_nb : TMO);
            m_rd    = (m_fault == 2'd0 && !req_store) ? ext(t_md, req_funct3) : 32'd0;
        end
    end

    task automatic monitor();
        bit rv, mem, iss;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_ctrl", 32'({req_ready, resp_valid, read_request_main, write_request_main}), 32'd0);
                check("reset_rdata", resp_rdata, 32'd0);
                check("reset_fault", 32'(resp_fault), 32'd0);
                check("reset_mem", address_main | write_data_main | 32'(width), 32'd0);
            end else begin
                rv  = act && k == fin;
                mem = act && k < fin;
                iss = mem && k == 0;
                check("ready", 32'(req_ready), 32'(!act));
                check("ctrl", 32'({resp_valid, read_request_main, write_request_main}),
                      32'({rv, iss && !m_st, iss && m_st}));
                check("rdata", resp_rdata, rv ? m_rd : 32'd0);
                check("fault", 32'(resp_fault), rv ? 32'(m_fault) : 32'd0);
                check("addr", address_main, mem ? m_ad : 32'd0);
                check("width", 32'(width), mem ? 32'(m_f3[1:0]) : 32'd0);
                check("wdata", write_data_main, mem ? m_wd : 32'd0);
                if (iss) last_w0 = width;
                if (mem && k == fin - 1) last_wd = write_data_main;
                if (read_request_main) obs_rr++;
                if (write_request_main) obs_wr++;
                if (resp_valid) begin
                    last_rd  = resp_rdata;
                    last_f   = resp_fault;
                    last_lat = act ? k : -1;
                end
            end
        end
    endtask

    task automatic wait_ready();
        int g = 0;
        while (!req_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!req_ready) check("ready_wait_bound", 32'(req_ready), 32'd1);
    endtask

    // Presents one access at a negedge and plays the memory: busy for nb WAIT cycles, then md.
    task automatic txn(input logic s, input logic [2:0] f, input logic [31:0] a, input logic [31:0] w,
                       input int nb, input logic [31:0] md);
        int len;
        wait_ready();
        obs_rr = 0; obs_wr = 0; last_lat = -1; last_rd = 32'hx; last_f = 2'bx;
        t_nb = nb; t_md = md;
        req_valid = 1'b1; req_store = s; req_funct3 = f; req_addr = a; req_wdata = w;
        busy_main = 1'b1; data_main = $urandom;
        @(negedge clk);
        req_valid = 1'b0; req_store = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        len = 4 + ((nb < TMO) ? nb : TMO);
        for (int i = 0; i < len; i++) begin
            busy_main = (i < 2) || (i - 2 < nb);
            data_main = busy_main ? $urandom : md;
            @(negedge clk);
        end
        busy_main = 1'b0;
    endtask

    initial begin
        req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        data_main = 32'd0; busy_main = 1'b0; t_nb = 0; t_md = 32'd0;
        obs_rr = 0; obs_wr = 0; last_lat = -1; last_rd = 32'd0; last_wd = 32'd0; last_f = 2'd0; last_w0 = 4'd0;
        fork monitor(); join_none
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        check("model_lb", ext(32'h0000_0080, 3'd0), 32'hFFFF_FF80);
        check("model_lbu", ext(32'h0000_0080, 3'd4), 32'h0000_0080);
        check("model_lh", ext(32'h1234_8001, 3'd1), 32'hFFFF_8001);
        check("model_lhu", ext(32'h1234_8001, 3'd5), 32'h0000_8001);

        txn(1'b0, 3'd2, 32'hC000_0010, 32'd0, 3, 32'hDEAD_BEEF);
        check("lw_rdata", last_rd, 32'hDEAD_BEEF);
        check("lw_fault", 32'(last_f), 32'd0);
        check("lw_latency", 32'(last_lat), 32'd6);
        check("lw_rreq_pulses", 32'(obs_rr), 32'd1);
        check("lw_width", 32'(last_w0), 32'd2);

        txn(1'b0, 3'd0, 32'hC000_0003, 32'd0, 1, 32'h0000_0080);
        check("lb_rdata", last_rd, 32'hFFFF_FF80);
        check("lb_width", 32'(last_w0), 32'd0);
        txn(1'b0, 3'd4, 32'hC000_0003, 32'd0, 0, 32'h0000_0080);
        check("lbu_rdata", last_rd, 32'h0000_0080);

        txn(1'b1, 3'd1, 32'hC000_0001, 32'hAAAA_5555, 0, 32'd0);
        check("sh_mis_fault", 32'(last_f), 32'd1);
        check("sh_mis_no_wreq", 32'(obs_wr), 32'd0);
        check("sh_mis_latency", 32'(last_lat), 32'd0);

        txn(1'b1, 3'd2, 32'hC000_0004, 32'h1234_5678, 2, 32'hFFFF_FFFF);
        check("sw_wdata_held", last_wd, 32'h1234_5678);
        check("sw_fault", 32'(last_f), 32'd0);
        check("sw_rdata", last_rd, 32'd0);
        check("sw_wreq_pulses", 32'(obs_wr), 32'd1);

        txn(1'b0, 3'd3, 32'hC000_0008, 32'd0, 0, 32'd0);
        check("illegal_fault", 32'(last_f), 32'd3);
        check("illegal_no_req", 32'(obs_rr + obs_wr), 32'd0);

        txn(1'b0, 3'd2, 32'hC000_0040, 32'd0, 40, 32'h5555_AAAA);
        check("timeout_fault", 32'(last_f), 32'd2);
        check("timeout_rdata", last_rd, 32'd0);
        check("timeout_latency", 32'(last_lat), 32'd11);

        txn(1'b0, 3'd2, 32'hC000_0044, 32'd0, TMO, 32'h0BAD_F00D);
        check("tie_fault", 32'(last_f), 32'd0);
        check("tie_rdata", last_rd, 32'h0BAD_F00D);

        wait_ready();
        t_nb = 6; t_md = 32'h1111_2222;
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'hC000_0020; busy_main = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", 32'({req_ready, resp_valid, read_request_main, write_request_main}), 32'd0);
        check("rst_mid_addr", address_main, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        busy_main = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 32'd1);
        txn(1'b0, 3'd2, 32'hC000_0030, 32'd0, 1, 32'hCAFE_0001);
        check("post_rst_lw", last_rd, 32'hCAFE_0001);
        check("post_rst_latency", 32'(last_lat), 32'd4);

        for (int n = 0; n < 200; n++)
            txn(1'($urandom), 3'($urandom), 32'hC000_0000 | ($urandom & 32'h0000_FFFF), $urandom,
                $urandom_range(0, 10), $urandom);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
